// File: rtl/data_sync_pulse.sv
// Multi-bit CDC receiver: synchronises only the bus_enable qualifier, edge-detects it and
// captures unsync_bus on each event. Define DATA_SYNC_ACK_EN to add the ack_toggle output.
module data_sync_pulse #(
  parameter int BUS_WIDTH   = 8,
  parameter int STAGE_COUNT = 2,
  parameter int TOGGLE_MODE = 0,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUS_WIDTH-1:0]   unsync_bus,
  input  logic                   bus_enable,
  output logic [BUS_WIDTH-1:0]   sync_bus,
  output logic                   enable_pulse,
  output logic [COUNT_WIDTH-1:0] pulse_count
`ifdef DATA_SYNC_ACK_EN
  ,
  output logic                   ack_toggle
`endif
);

  logic [STAGE_COUNT-1:0] sync_q;
  logic                   s_last;
  logic                   prev_q;
  logic                   sync_event;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGE_COUNT-2:0], bus_enable};
      prev_q <= s_last;
    end
  end

  assign s_last = sync_q[STAGE_COUNT-1];

  // Level mode only reacts to 0->1; toggle mode treats either transition as a new transfer.
  assign sync_event = (TOGGLE_MODE != 0) ? (s_last ^ prev_q) : (s_last & ~prev_q);

  // unsync_bus is only looked at in an event cycle, when the source guarantees it is stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_bus     <= '0;
      enable_pulse <= 1'b0;
      pulse_count  <= '0;
    end else begin
      enable_pulse <= sync_event;
      pulse_count  <= pulse_count + COUNT_WIDTH'(sync_event);
      if (sync_event) begin
        sync_bus <= unsync_bus;
      end
    end
  end

`ifdef DATA_SYNC_ACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_toggle <= 1'b0;
    end else begin
      ack_toggle <= ack_toggle ^ sync_event;
    end
  end
`endif

endmodule
